// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: read port of the capture dual-port RAM.
// raddr: pixel address from the reader; rdata: stored pixel bit.
interface vga_frame_reader_if;
  logic [17:0] raddr;
  logic        rdata;

  modport master (
    output raddr,
    input  rdata
  );

  modport slave (
    input  raddr,
    output rdata
  );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans a 1-bpp framebuffer out as VGA with
// line doubling, vertical borders and a synchronised test pattern.
// Ports: pixclk, rst_n (async, low); ram (raddr/rdata RAM read port);
// pattern_en (async checkerboard select); hsync, vsync, red, green,
// blue to the connector; frame_start marks a frame's first pixel.
module vga_frame_reader #(
  parameter logic [11:0] FG_RGB     = 12'h0F0,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter logic [11:0] BORDER_RGB = 12'h000,
  parameter int          RD_LATENCY = 2,
  parameter int          H_VISIBLE  = 800,
  parameter int          H_FRONT    = 40,
  parameter int          H_SYNC     = 128,
  parameter int          H_BACK     = 88,
  parameter int          V_VISIBLE  = 600,
  parameter int          V_FRONT    = 1,
  parameter int          V_SYNC     = 4,
  parameter int          V_BACK     = 23,
  parameter int          V_BORDER   = 60
) (
  input  logic               pixclk,
  input  logic               rst_n,
  vga_frame_reader_if.master ram,
  input  logic               pattern_en,
  output logic               hsync,
  output logic               vsync,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               frame_start
);

  typedef logic [10:0] h_t;
  typedef logic [9:0]  v_t;
  typedef logic [17:0] a_t;

  localparam h_t H_VIS  = h_t'(H_VISIBLE);
  localparam h_t HS_BEG = h_t'(H_VISIBLE + H_FRONT);
  localparam h_t HS_END = h_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam h_t H_LAST =
    h_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);

  localparam v_t V_VIS  = v_t'(V_VISIBLE);
  localparam v_t VS_BEG = v_t'(V_VISIBLE + V_FRONT);
  localparam v_t VS_END = v_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam v_t V_LAST =
    v_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  localparam v_t FB_TOP  = v_t'(V_BORDER);
  localparam v_t FB_END  = v_t'(V_VISIBLE - V_BORDER);
  localparam v_t FB_LAST = v_t'(V_VISIBLE - V_BORDER - 1);
  localparam a_t STRIDE  = a_t'(H_VISIBLE);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic area;
    logic pm;
    logic chk;
    logic fs;
  } tag_t;

  h_t   hcnt, hcnt_n;
  v_t   vcnt, vcnt_n;
  a_t   linebase, lb_n;
  a_t   raddr_q, raddr_n;
  logic h_wrap, v_wrap, lb_step;
  logic pat_s1, pat_s2, pat_mode;
  tag_t cur, tap;
  tag_t pipe [RD_LATENCY];
  logic [11:0] rgb;

  function automatic logic in_fb(h_t h, v_t v);
    return h < H_VIS && v >= FB_TOP && v < FB_END;
  endfunction

  // Each source row spans two scan lines; the base moves on only
  // after the second copy, and never past the last row.
  assign lb_step = vcnt >= FB_TOP && vcnt < FB_LAST &&
                   (vcnt[0] ^ FB_TOP[0]);

  always_comb begin
    h_wrap = hcnt == H_LAST;
    v_wrap = vcnt == V_LAST;
    hcnt_n = h_wrap ? '0 : hcnt + 11'd1;
    vcnt_n = vcnt;
    lb_n   = linebase;
    if (h_wrap) begin
      vcnt_n = v_wrap ? '0 : vcnt + 10'd1;
      if (v_wrap)
        lb_n = '0;
      else if (lb_step)
        lb_n = linebase + STRIDE;
    end
    // Address is produced for the next counter value so it sits in
    // the same cycle as the counter it belongs to.
    raddr_n = in_fb(hcnt_n, vcnt_n) ?
              lb_n + a_t'(hcnt_n) : raddr_q;
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      linebase <= '0;
      raddr_q  <= '0;
    end else begin
      hcnt     <= hcnt_n;
      vcnt     <= vcnt_n;
      linebase <= lb_n;
      raddr_q  <= raddr_n;
    end
  end

  assign ram.raddr = raddr_q;

  // Mode only changes on the edge into pixel (0,0).
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      pat_s1   <= 1'b0;
      pat_s2   <= 1'b0;
      pat_mode <= 1'b0;
    end else begin
      pat_s1 <= pattern_en;
      pat_s2 <= pat_s1;
      if (h_wrap && v_wrap)
        pat_mode <= pat_s2;
    end
  end

  always_comb begin
    cur      = '0;
    cur.hs   = hcnt >= HS_BEG && hcnt < HS_END;
    cur.vs   = vcnt >= VS_BEG && vcnt < VS_END;
    cur.vis  = hcnt < H_VIS && vcnt < V_VIS;
    cur.area = cur.vis && vcnt >= FB_TOP && vcnt < FB_END;
    cur.pm   = pat_mode;
    cur.chk  = hcnt[3] ^ vcnt[3];
    cur.fs   = hcnt == '0 && vcnt == '0;
  end

  // Tags travel alongside the RAM access so they meet rdata.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < RD_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tap = pipe[RD_LATENCY-1];

  always_comb begin
    rgb = '0;
    unique case (1'b1)
      !tap.vis:
        rgb = '0;
      tap.vis && tap.pm:
        rgb = tap.chk ? FG_RGB : BG_RGB;
      tap.vis && !tap.pm && tap.area:
        rgb = ram.rdata ? FG_RGB : BG_RGB;
      tap.vis && !tap.pm && !tap.area:
        rgb = BORDER_RGB;
      default:
        rgb = '0;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= tap.hs;
      vsync       <= tap.vs;
      red         <= rgb[11:8];
      green       <= rgb[7:4];
      blue        <= rgb[3:0];
      frame_start <= tap.fs;
    end
  end

endmodule
